// File: rtl/fir4_rr_sched.sv
// Round-robin scheduler sharing one 4-tap moving-sum FIR datapath among N sample channels.
// Optional per-channel synchronous history clear port enabled by FIR_SCHED_CLEAR_EN.
module fir4_rr_sched #(
    parameter int W = 16,
    parameter int N = 4,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W+1:0]     out_data,
    output logic [CW-1:0]    out_ch,
`ifdef FIR_SCHED_CLEAR_EN
    input  logic [N-1:0]     clr,
`endif
    input  logic             out_ready
);

    logic [W-1:0]  r_h0 [N];
    logic [W-1:0]  r_h1 [N];
    logic [W-1:0]  r_h2 [N];
    logic [CW-1:0] r_ptr;
    logic          r_out_valid;
    logic [W+1:0]  r_out_data;
    logic [CW-1:0] r_out_ch;

    logic          w_free;
    logic          w_hi_found;
    logic [CW-1:0] w_hi_sel;
    logic          w_lo_found;
    logic [CW-1:0] w_lo_sel;
    logic          w_found;
    logic [CW-1:0] w_sel;
    logic          w_accept;
    logic [W-1:0]  w_x;
    logic [W-1:0]  w_sel_h0;
    logic [W-1:0]  w_sel_h1;
    logic [W-1:0]  w_sel_h2;
    logic [W+1:0]  w_sum;
    logic [CW-1:0] w_ptr_next;
    logic          w_sel_clr;

    // Reset gates the slot so no grant escapes while reset_n is low.
    assign w_free = reset_n && (!r_out_valid || out_ready);

    // Rotating priority: lowest requester at or above ptr wins, else lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_sel   = '0;
        w_lo_found = 1'b0;
        w_lo_sel   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                w_lo_found = 1'b1;
                w_lo_sel   = CW'(k);
                if (CW'(k) >= r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_sel   = CW'(k);
                end
            end
        end
    end

    assign w_found  = w_hi_found || w_lo_found;
    assign w_sel    = w_hi_found ? w_hi_sel : w_lo_sel;
    assign w_accept = w_free && w_found;
    assign in_ready = w_accept ? (N'(1) << w_sel) : '0;

`ifdef FIR_SCHED_CLEAR_EN
    assign w_sel_clr = clr[w_sel];
`else
    assign w_sel_clr = 1'b0;
`endif

    assign w_x      = in_data[w_sel*W +: W];
    assign w_sel_h0 = w_sel_clr ? '0 : r_h0[w_sel];
    assign w_sel_h1 = w_sel_clr ? '0 : r_h1[w_sel];
    assign w_sel_h2 = w_sel_clr ? '0 : r_h2[w_sel];
    assign w_sum    = (W+2)'(w_x) + (W+2)'(w_sel_h0) + (W+2)'(w_sel_h1) + (W+2)'(w_sel_h2);
    assign w_ptr_next = (w_sel == CW'(N - 1)) ? '0 : w_sel + CW'(1);

    // Accept path writes the granted channel last so it overrides any clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                r_h0[k] <= '0;
                r_h1[k] <= '0;
                r_h2[k] <= '0;
            end
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else begin
`ifdef FIR_SCHED_CLEAR_EN
            for (int k = 0; k < N; k++) begin
                if (clr[k]) begin
                    r_h0[k] <= '0;
                    r_h1[k] <= '0;
                    r_h2[k] <= '0;
                end
            end
`endif
            if (w_accept) begin
                r_h2[w_sel] <= w_sel_h1;
                r_h1[w_sel] <= w_sel_h0;
                r_h0[w_sel] <= w_x;
                r_ptr       <= w_ptr_next;
                r_out_valid <= 1'b1;
                r_out_data  <= w_sum;
                r_out_ch    <= w_sel;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule
